// File: rtl/pipe_latch_fd_dx_mw.sv
// Three independent inter-stage pipeline latches: F/D, D/X and M/W.
// Each stage stores all of its fields together, holds them while its
// enable is low, and is cleared to the all-zero nop on reset.
module pipe_latch_fd_dx_mw #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,

    input  logic         fd_en,
    input  logic [W-1:0] fd_ir_in,
    input  logic [W-1:0] fd_pc_in,
    output logic [W-1:0] fd_ir_out,
    output logic [W-1:0] fd_pc_out,

    input  logic         dx_en,
    input  logic [W-1:0] dx_ir_in,
    input  logic [W-1:0] dx_pc_in,
    input  logic [W-1:0] dx_a_in,
    input  logic [W-1:0] dx_b_in,
    output logic [W-1:0] dx_ir_out,
    output logic [W-1:0] dx_pc_out,
    output logic [W-1:0] dx_a_out,
    output logic [W-1:0] dx_b_out,

    input  logic         mw_en,
    input  logic [W-1:0] mw_ir_in,
    input  logic [W-1:0] mw_o_in,
    input  logic [W-1:0] mw_d_in,
    output logic [W-1:0] mw_ir_out,
    output logic [W-1:0] mw_o_out,
    output logic [W-1:0] mw_d_out
);

    logic [W-1:0] fdIr_q, fdIr_d;
    logic [W-1:0] fdPc_q, fdPc_d;

    logic [W-1:0] dxIr_q, dxIr_d;
    logic [W-1:0] dxPc_q, dxPc_d;
    logic [W-1:0] dxA_q,  dxA_d;
    logic [W-1:0] dxB_q,  dxB_d;

    logic [W-1:0] mwIr_q, mwIr_d;
    logic [W-1:0] mwO_q,  mwO_d;
    logic [W-1:0] mwD_q,  mwD_d;

    // F/D next state: load the whole stage on enable, otherwise hold it as a unit.
    always_comb begin
        fdIr_d = fdIr_q;
        fdPc_d = fdPc_q;
        if (fd_en) begin
            fdIr_d = fd_ir_in;
            fdPc_d = fd_pc_in;
        end
    end

    // D/X next state: instruction, PC and both operands move together.
    always_comb begin
        dxIr_d = dxIr_q;
        dxPc_d = dxPc_q;
        dxA_d  = dxA_q;
        dxB_d  = dxB_q;
        if (dx_en) begin
            dxIr_d = dx_ir_in;
            dxPc_d = dx_pc_in;
            dxA_d  = dx_a_in;
            dxB_d  = dx_b_in;
        end
    end

    // M/W next state: instruction, result and memory data move together.
    always_comb begin
        mwIr_d = mwIr_q;
        mwO_d  = mwO_q;
        mwD_d  = mwD_q;
        if (mw_en) begin
            mwIr_d = mw_ir_in;
            mwO_d  = mw_o_in;
            mwD_d  = mw_d_in;
        end
    end

    // F/D register; reset wins over enable and leaves a nop in the stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            fdIr_q <= '0;
            fdPc_q <= '0;
        end else begin
            fdIr_q <= fdIr_d;
            fdPc_q <= fdPc_d;
        end
    end

    // D/X register; reset wins over enable and leaves a nop in the stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            dxIr_q <= '0;
            dxPc_q <= '0;
            dxA_q  <= '0;
            dxB_q  <= '0;
        end else begin
            dxIr_q <= dxIr_d;
            dxPc_q <= dxPc_d;
            dxA_q  <= dxA_d;
            dxB_q  <= dxB_d;
        end
    end

    // M/W register; reset wins over enable and leaves a nop in the stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            mwIr_q <= '0;
            mwO_q  <= '0;
            mwD_q  <= '0;
        end else begin
            mwIr_q <= mwIr_d;
            mwO_q  <= mwO_d;
            mwD_q  <= mwD_d;
        end
    end

    // Outputs come straight from the registers so no input reaches an output combinationally.
    assign fd_ir_out = fdIr_q;
    assign fd_pc_out = fdPc_q;
    assign dx_ir_out = dxIr_q;
    assign dx_pc_out = dxPc_q;
    assign dx_a_out  = dxA_q;
    assign dx_b_out  = dxB_q;
    assign mw_ir_out = mwIr_q;
    assign mw_o_out  = mwO_q;
    assign mw_d_out  = mwD_q;

endmodule

// File: tb/tb_pipe_latch_fd_dx_mw.sv
// Testbench for pipe_latch_fd_dx_mw: directed scenarios followed by random traffic,
// all compared against a stage-level model of the three latches.
module tb_pipe_latch_fd_dx_mw;

    logic        clock;
    logic        reset;
    logic        fdEn, dxEn, mwEn;
    logic [31:0] fdIrIn, fdPcIn;
    logic [31:0] dxIrIn, dxPcIn, dxAIn, dxBIn;
    logic [31:0] mwIrIn, mwOIn, mwDIn;
    logic [31:0] fdIrOut, fdPcOut;
    logic [31:0] dxIrOut, dxPcOut, dxAOut, dxBOut;
    logic [31:0] mwIrOut, mwOOut, mwDOut;

    // Expected contents of each stage as a plain word array
    logic [31:0] modelFd [2];
    logic [31:0] modelDx [4];
    logic [31:0] modelMw [3];

    int compareCount  = 0;
    int mismatchCount = 0;

    pipe_latch_fd_dx_mw #(.W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .fd_en     (fdEn),
        .fd_ir_in  (fdIrIn),
        .fd_pc_in  (fdPcIn),
        .fd_ir_out (fdIrOut),
        .fd_pc_out (fdPcOut),
        .dx_en     (dxEn),
        .dx_ir_in  (dxIrIn),
        .dx_pc_in  (dxPcIn),
        .dx_a_in   (dxAIn),
        .dx_b_in   (dxBIn),
        .dx_ir_out (dxIrOut),
        .dx_pc_out (dxPcOut),
        .dx_a_out  (dxAOut),
        .dx_b_out  (dxBOut),
        .mw_en     (mwEn),
        .mw_ir_in  (mwIrIn),
        .mw_o_in   (mwOIn),
        .mw_d_in   (mwDIn),
        .mw_ir_out (mwIrOut),
        .mw_o_out  (mwOOut),
        .mw_d_out  (mwDOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one clock edge: reset clears, enable loads a whole stage, else hold
    task automatic updateModel();
        if (reset) begin
            foreach (modelFd[i]) modelFd[i] = '0;
            foreach (modelDx[i]) modelDx[i] = '0;
            foreach (modelMw[i]) modelMw[i] = '0;
        end else begin
            if (fdEn) modelFd = '{fdIrIn, fdPcIn};
            if (dxEn) modelDx = '{dxIrIn, dxPcIn, dxAIn, dxBIn};
            if (mwEn) modelMw = '{mwIrIn, mwOIn, mwDIn};
        end
    endtask

    task automatic checkAll(input string phase);
        checkOutput({phase, ".fd_ir"}, fdIrOut, modelFd[0]);
        checkOutput({phase, ".fd_pc"}, fdPcOut, modelFd[1]);
        checkOutput({phase, ".dx_ir"}, dxIrOut, modelDx[0]);
        checkOutput({phase, ".dx_pc"}, dxPcOut, modelDx[1]);
        checkOutput({phase, ".dx_a"},  dxAOut,  modelDx[2]);
        checkOutput({phase, ".dx_b"},  dxBOut,  modelDx[3]);
        checkOutput({phase, ".mw_ir"}, mwIrOut, modelMw[0]);
        checkOutput({phase, ".mw_o"},  mwOOut,  modelMw[1]);
        checkOutput({phase, ".mw_d"},  mwDOut,  modelMw[2]);
    endtask

    // One rising edge; inputs then change 1ns later, away from the edge
    task automatic applyStimulus(input string phase);
        @(posedge clock);
        updateModel();
        #1;
        checkAll(phase);
    endtask

    task automatic randomizeData();
        fdIrIn = $urandom; fdPcIn = $urandom;
        dxIrIn = $urandom; dxPcIn = $urandom; dxAIn = $urandom; dxBIn = $urandom;
        mwIrIn = $urandom; mwOIn  = $urandom; mwDIn = $urandom;
    endtask

    initial begin
        foreach (modelFd[i]) modelFd[i] = '0;
        foreach (modelDx[i]) modelDx[i] = '0;
        foreach (modelMw[i]) modelMw[i] = '0;
        reset = 1'b1;
        fdEn = 1'b1; dxEn = 1'b1; mwEn = 1'b1;
        randomizeData();
        #2;
        applyStimulus("init");

        // Load nonzero values, then reset with every enable high
        reset = 1'b0;
        randomizeData();
        applyStimulus("preload");
        reset = 1'b1;
        randomizeData();
        applyStimulus("reset");
        checkOutput("reset.mw_d_zero", mwDOut, 32'h0);
        checkOutput("reset.fd_ir_zero", fdIrOut, 32'h0);

        // Capture into F/D; outputs unchanged until the edge
        reset = 1'b0;
        fdIrIn = 32'h28A00005; fdPcIn = 32'd7;
        #1;
        checkOutput("capture.before", fdIrOut, 32'h0);
        applyStimulus("capture");
        checkOutput("capture.ir", fdIrOut, 32'h28A00005);
        checkOutput("capture.pc", fdPcOut, 32'd7);

        // Stall: F/D holds for three edges while its inputs change
        fdEn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fdIrIn = 32'h0; fdPcIn = $urandom;
            applyStimulus("stall");
            checkOutput("stall.ir", fdIrOut, 32'h28A00005);
            checkOutput("stall.pc", fdPcOut, 32'd7);
        end
        fdEn = 1'b1; fdPcIn = 32'd8;
        applyStimulus("unstall");
        checkOutput("unstall.ir", fdIrOut, 32'h0);
        checkOutput("unstall.pc", fdPcOut, 32'd8);

        // Reset beats enable, then the first edge after reset captures normally
        dxAIn = 32'hFFFFFFFF;
        reset = 1'b1;
        applyStimulus("rstbeats");
        checkOutput("rstbeats.a", dxAOut, 32'h0);
        reset = 1'b0;
        applyStimulus("afterrst");
        checkOutput("afterrst.a", dxAOut, 32'hFFFFFFFF);

        // Bubble through D/X
        dxIrIn = 32'h0; dxPcIn = 32'd12; dxAIn = 32'd3; dxBIn = 32'd4;
        applyStimulus("bubble");
        checkOutput("bubble.ir", dxIrOut, 32'h0);
        checkOutput("bubble.pc", dxPcOut, 32'd12);
        checkOutput("bubble.a",  dxAOut,  32'd3);
        checkOutput("bubble.b",  dxBOut,  32'd4);

        // M/W updates while F/D holds
        fdEn = 1'b0; mwEn = 1'b1;
        fdIrIn = 32'hFFFFFFFF; fdPcIn = 32'hFFFFFFFF;
        mwIrIn = 32'h40400000; mwOIn = 32'd100; mwDIn = 32'hDEADBEEF;
        applyStimulus("indep");
        checkOutput("indep.mw_ir", mwIrOut, 32'h40400000);
        checkOutput("indep.mw_o",  mwOOut,  32'd100);
        checkOutput("indep.mw_d",  mwDOut,  32'hDEADBEEF);
        checkOutput("indep.fd_pc", fdPcOut, 32'd8);

        // Random traffic with occasional reset and independent enables
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 19) == 0);
            fdEn  = $urandom_range(0, 1) == 1;
            dxEn  = $urandom_range(0, 3) != 0;
            mwEn  = $urandom_range(0, 3) != 0;
            randomizeData();
            if ($urandom_range(0, 7) == 0) begin
                dxAIn = 32'hFFFFFFFF; mwDIn = 32'hFFFFFFFF;
            end
            applyStimulus("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
